// File: rtl/ticket_vending_ctrl.sv
// Station-ticket vending controller: prices a journey, collects coins, dispenses
// tickets over valid/ready and returns change, with cancel and inactivity timeout.
module ticket_vending_ctrl #(
  parameter int unsigned STATION_W   = 3,
  parameter int unsigned TICKET_W    = 3,
  parameter int unsigned COIN_W      = 6,
  parameter int unsigned MONEY_W     = 10,
  parameter int unsigned FARE_UNIT   = 5,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [STATION_W-1:0] origin,
  input  logic [STATION_W-1:0] destination,
  input  logic [TICKET_W-1:0]  howManyTicket,
  input  logic                 coin_valid,
  input  logic [COIN_W-1:0]    money,
  input  logic                 cancel,
  input  logic                 ticket_ready,
  output logic [MONEY_W-1:0]   costOfTicket,
  output logic [MONEY_W-1:0]   moneyToPay,
  output logic [MONEY_W-1:0]   totalMoney,
  output logic [MONEY_W-1:0]   change,
  output logic                 ticket_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 cancelled
);

  typedef enum logic [2:0] {IDLE, PRICE, TOTAL, PAY, DISPENSE, FINISH, REFUND} state_t;

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned SUM_W = ((MONEY_W > COIN_W) ? MONEY_W : COIN_W) + 1;
  localparam logic [MONEY_W-1:0] MONEY_MAX = '1;

  state_t               state_q, state_d;
  logic [STATION_W-1:0] orig_q, orig_d, dest_q, dest_d, span;
  logic [TICKET_W-1:0]  tix_q, tix_d, hs_q, hs_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [MONEY_W-1:0]   cost_d, due_d, total_d, change_d, sat_total;
  logic [SUM_W-1:0]     sum;
  logic                 tv_d, busy_d, done_d, cancelled_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      orig_q       <= '0;
      dest_q       <= '0;
      tix_q        <= '0;
      hs_q         <= '0;
      tmr_q        <= '0;
      costOfTicket <= '0;
      moneyToPay   <= '0;
      totalMoney   <= '0;
      change       <= '0;
      ticket_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cancelled    <= 1'b0;
    end else begin
      state_q      <= state_d;
      orig_q       <= orig_d;
      dest_q       <= dest_d;
      tix_q        <= tix_d;
      hs_q         <= hs_d;
      tmr_q        <= tmr_d;
      costOfTicket <= cost_d;
      moneyToPay   <= due_d;
      totalMoney   <= total_d;
      change       <= change_d;
      ticket_valid <= tv_d;
      busy         <= busy_d;
      done         <= done_d;
      cancelled    <= cancelled_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    orig_d      = orig_q;
    dest_d      = dest_q;
    tix_d       = tix_q;
    hs_d        = hs_q;
    tmr_d       = tmr_q;
    cost_d      = costOfTicket;
    due_d       = moneyToPay;
    total_d     = totalMoney;
    change_d    = change;
    tv_d        = ticket_valid;
    done_d      = 1'b0;
    cancelled_d = 1'b0;

    span      = (dest_q >= orig_q) ? (dest_q - orig_q) : (orig_q - dest_q);
    sum       = SUM_W'(totalMoney) + SUM_W'(money);
    sat_total = (sum > SUM_W'(MONEY_MAX)) ? MONEY_MAX : sum[MONEY_W-1:0];

    // Pulses and change are decided on the transition so they appear together
    // with the FINISH/REFUND state rather than one cycle after it.
    case (state_q)
      IDLE: begin
        if (start && (howManyTicket != '0)) begin
          orig_d  = origin;
          dest_d  = destination;
          tix_d   = howManyTicket;
          state_d = PRICE;
        end
      end
      PRICE: begin
        cost_d   = (MONEY_W'(span) + MONEY_W'(1)) * MONEY_W'(FARE_UNIT);
        due_d    = '0;
        total_d  = '0;
        change_d = '0;
        hs_d     = '0;
        state_d  = TOTAL;
      end
      TOTAL: begin
        due_d   = MONEY_W'(tix_q) * costOfTicket;
        tmr_d   = TMR_W'(TIMEOUT_CYC);
        state_d = PAY;
      end
      PAY: begin
        if (cancel) begin
          change_d    = totalMoney;
          cancelled_d = 1'b1;
          state_d     = REFUND;
        end else if (coin_valid) begin
          total_d = sat_total;
          tmr_d   = TMR_W'(TIMEOUT_CYC);
          if (sat_total >= moneyToPay) begin
            tv_d    = 1'b1;
            state_d = DISPENSE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
          if (tmr_q <= TMR_W'(1)) begin
            change_d    = totalMoney;
            cancelled_d = 1'b1;
            state_d     = REFUND;
          end
        end
      end
      DISPENSE: begin
        if (ticket_ready) begin
          hs_d = hs_q + TICKET_W'(1);
          if ((hs_q + TICKET_W'(1)) == tix_q) begin
            tv_d     = 1'b0;
            change_d = totalMoney - moneyToPay;
            done_d   = 1'b1;
            state_d  = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      REFUND:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_ticket_vending_ctrl.sv
// Randomised scoreboard bench for ticket_vending_ctrl against a journey-level model.
module tb_ticket_vending_ctrl;
  localparam int unsigned SW = 3, TW = 3, CW = 6, MW = 10, FU = 5, TO = 8, SMW = 6;
  localparam int MAXM  = (1 << MW) - 1;
  localparam int SMAXM = (1 << SMW) - 1;

  typedef struct { bit cv; int m; bit cn; bit rdy; } act_t;
  typedef struct { bit is_done; int cost; int due; int total; int chg; int tickets; int end_cyc; } exp_t;

  logic clk = 1'b0;
  logic reset, start, coin_valid, cancel, ticket_ready;
  logic [SW-1:0] origin, destination;
  logic [TW-1:0] how;
  logic [CW-1:0] money;
  logic [MW-1:0] cost, due, total, chg;
  logic tv, busy, done, cancelled;

  logic s_start, s_coin_valid, s_cancel, s_ready, s_how;
  logic [SW-1:0] s_origin, s_dest;
  logic [CW-1:0] s_money;
  logic [SMW-1:0] s_cost, s_due, s_total, s_chg;
  logic s_tv, s_busy, s_done, s_cancelled;

  ticket_vending_ctrl #(.STATION_W(SW), .TICKET_W(TW), .COIN_W(CW), .MONEY_W(MW),
                        .FARE_UNIT(FU), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .origin(origin), .destination(destination),
    .howManyTicket(how), .coin_valid(coin_valid), .money(money), .cancel(cancel),
    .ticket_ready(ticket_ready), .costOfTicket(cost), .moneyToPay(due), .totalMoney(total),
    .change(chg), .ticket_valid(tv), .busy(busy), .done(done), .cancelled(cancelled));

  ticket_vending_ctrl #(.STATION_W(SW), .TICKET_W(1), .COIN_W(CW), .MONEY_W(SMW),
                        .FARE_UNIT(FU), .TIMEOUT_CYC(TO)) dut_sat (
    .clk(clk), .reset(reset), .start(s_start), .origin(s_origin), .destination(s_dest),
    .howManyTicket(s_how), .coin_valid(s_coin_valid), .money(s_money), .cancel(s_cancel),
    .ticket_ready(s_ready), .costOfTicket(s_cost), .moneyToPay(s_due), .totalMoney(s_total),
    .change(s_chg), .ticket_valid(s_tv), .busy(s_busy), .done(s_done), .cancelled(s_cancelled));

  always #5 clk = ~clk;

  int   cyc = 0;
  int   tests = 0, fails = 0;
  bit   track = 1'b0, exp_busy = 1'b0, exp_tv = 1'b0;
  int   mtot = 0, hs_seen = 0;
  exp_t q[$], sq[$];
  act_t aq[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic act_t A(input bit cv, input int m, input bit cn, input bit rdy);
    act_t a;
    a.cv = cv; a.m = m; a.cn = cn; a.rdy = rdy;
    return a;
  endfunction

  // mode 0: idle with ready high; 1: coin-heavy random; 2: sparse random (timeouts likely)
  function automatic act_t gen(input int mode, input bit in_disp, input int guard);
    act_t a = A(1'b0, 0, 1'b0, 1'b1);
    if (mode == 0) return a;
    a.m = int'($urandom_range(0, 63));
    if (!in_disp) begin
      a.cn = ($urandom_range(0, 99) < 2);
      a.cv = ($urandom_range(0, 99) < ((mode == 1) ? 50 : 12));
    end else begin
      a.cn  = ($urandom_range(0, 3) == 0);
      a.cv  = ($urandom_range(0, 3) == 0);
      a.rdy = (guard > 80) || ($urandom_range(0, 1) == 1);
    end
    return a;
  endfunction

  task automatic run_txn(input int o, input int d, input int n, input int abort_hs, input int mode);
    int cost_m, due_m, tot, idle, hs, guard;
    bit in_disp, ended, was_done, aborted;
    act_t a;
    exp_t e;
    origin = SW'(o); destination = SW'(d); how = TW'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      repeat (2) begin @(posedge clk); #1; end
      return;
    end
    exp_busy = 1'b1; exp_tv = 1'b0;
    cost_m = (((d > o) ? d - o : o - d) + 1) * FU;
    due_m  = n * cost_m;
    @(posedge clk); #1;
    mtot = 0;
    @(posedge clk); #1;
    tot = 0; idle = 0; hs = 0; guard = 0;
    in_disp = 1'b0; ended = 1'b0; was_done = 1'b0; aborted = 1'b0;
    while (!ended && !aborted) begin
      if (aq.size() != 0) a = aq.pop_front();
      else a = gen(mode, in_disp, guard);
      coin_valid = a.cv; money = CW'(a.m); cancel = a.cn; ticket_ready = a.rdy;
      if (mode != 0) begin
        start = 1'($urandom_range(0, 1));
        origin = SW'($urandom); destination = SW'($urandom); how = TW'($urandom);
      end
      @(posedge clk); #1;
      guard++;
      if (!in_disp) begin
        if (a.cn) ended = 1'b1;
        else if (a.cv) begin
          tot = (tot + a.m > MAXM) ? MAXM : tot + a.m;
          idle = 0;
          in_disp = (tot >= due_m);
        end else begin
          idle++;
          ended = (idle == TO);
        end
        mtot = tot;
      end else if (a.rdy) begin
        hs++;
        if (hs == n) begin ended = 1'b1; was_done = 1'b1; end
        else if (hs == abort_hs) aborted = 1'b1;
      end
      exp_tv = in_disp && !ended;
    end
    if (aborted) begin
      #1 reset = 1'b1;
      exp_busy = 1'b0; exp_tv = 1'b0; mtot = 0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_ticket_valid", int'(tv), 0);
      chk("rst_cost", int'(cost), 0);
      chk("rst_due", int'(due), 0);
      chk("rst_total", int'(total), 0);
      chk("rst_change", int'(chg), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_cancelled", int'(cancelled), 0);
      @(negedge clk); #2 reset = 1'b0;
    end else begin
      e.is_done = was_done; e.cost = cost_m; e.due = due_m; e.total = tot;
      e.chg = was_done ? tot - due_m : tot;
      e.tickets = was_done ? n : 0;
      e.end_cyc = cyc;
      q.push_back(e);
      coin_valid = 1'b0; cancel = 1'b0; start = 1'b0; ticket_ready = 1'b0;
      @(posedge clk); #1;
      exp_busy = 1'b0;
    end
    coin_valid = 1'b0; cancel = 1'b0; start = 1'b0; ticket_ready = 1'b0; money = '0;
    aq.delete();
  endtask

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) hs_seen = 0;
      else if (track) begin
        chk("busy", int'(busy), int'(exp_busy));
        chk("ticket_valid", int'(tv), int'(exp_tv));
        chk("totalMoney", int'(total), mtot);
        chk("done_cancel_excl", int'(done & cancelled), 0);
        if (tv && ticket_ready) hs_seen++;
        if (done || cancelled) begin
          chk("pending_expect", q.size(), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("outcome_done", int'(done), int'(e.is_done));
            chk("costOfTicket", int'(cost), e.cost);
            chk("moneyToPay", int'(due), e.due);
            chk("change", int'(chg), e.chg);
            chk("tickets", hs_seen, e.tickets);
            chk("end_cycle", cyc, e.end_cyc);
          end
          hs_seen = 0;
        end
      end
    end
  end

  initial begin : smon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (s_done || s_cancelled)) begin
        chk("sat_pending", sq.size(), 1);
        if (sq.size() != 0) begin
          e = sq.pop_front();
          chk("sat_done", int'(s_done), int'(e.is_done));
          chk("sat_cost", int'(s_cost), e.cost);
          chk("sat_due", int'(s_due), e.due);
          chk("sat_total", int'(s_total), e.total);
          chk("sat_change", int'(s_chg), e.chg);
        end
      end
    end
  end

  initial begin : drv
    exp_t e;
    reset = 1'b1; start = 1'b0; origin = '0; destination = '0; how = '0;
    coin_valid = 1'b0; money = '0; cancel = 1'b0; ticket_ready = 1'b0;
    s_start = 1'b0; s_origin = '0; s_dest = '0; s_how = 1'b0;
    s_coin_valid = 1'b0; s_money = '0; s_cancel = 1'b0; s_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_cost", int'(cost), 0);
    chk("reset_total", int'(total), 0);
    chk("reset_change", int'(chg), 0);
    chk("reset_tv", int'(tv), 0);
    chk("reset_done", int'(done | cancelled), 0);
    @(negedge clk);
    reset = 1'b0;
    track = 1'b1;
    @(posedge clk); #1;

    aq.push_back(A(1, 20, 0, 1)); aq.push_back(A(1, 10, 0, 1)); aq.push_back(A(1, 15, 0, 1));
    run_txn(2, 5, 2, 0, 0);
    aq.push_back(A(1, 30, 0, 1));
    run_txn(6, 1, 1, 0, 0);
    aq.push_back(A(1, 5, 0, 1));
    run_txn(3, 3, 1, 0, 0);
    run_txn(4, 2, 0, 0, 0);
    aq.push_back(A(1, 10, 0, 0)); aq.push_back(A(1, 5, 1, 0));
    run_txn(1, 4, 1, 0, 0);
    aq.push_back(A(1, 5, 0, 1));
    run_txn(0, 3, 1, 0, 0);
    aq.push_back(A(1, 5, 0, 1));
    for (int i = 0; i < 7; i++) aq.push_back(A(0, 0, 0, 1));
    aq.push_back(A(1, 5, 0, 1));
    run_txn(0, 3, 1, 0, 0);
    aq.push_back(A(1, 30, 0, 1));
    aq.push_back(A(0, 0, 1, 1)); aq.push_back(A(0, 0, 0, 0)); aq.push_back(A(0, 0, 1, 0));
    aq.push_back(A(0, 0, 0, 1)); aq.push_back(A(1, 9, 0, 0)); aq.push_back(A(0, 0, 1, 1));
    run_txn(0, 1, 3, 0, 0);
    aq.push_back(A(1, 30, 0, 1));
    run_txn(0, 1, 3, 1, 0);
    aq.push_back(A(1, 20, 0, 1)); aq.push_back(A(1, 10, 0, 1)); aq.push_back(A(1, 15, 0, 1));
    run_txn(2, 5, 2, 0, 0);

    for (int i = 0; i < 40; i++)
      run_txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), 0, int'($urandom_range(1, 2)));

    s_origin = '0; s_dest = 3'd7; s_how = 1'b1; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    s_coin_valid = 1'b1; s_money = 6'd5;
    @(posedge clk); #1;
    chk("sat_partial", int'(s_total), 5);
    s_money = 6'd60;
    @(posedge clk); #1;
    s_coin_valid = 1'b0; s_money = '0;
    chk("sat_clamp", int'(s_total), SMAXM);
    chk("sat_tv", int'(s_tv), 1);
    e.is_done = 1'b1; e.cost = (7 + 1) * FU; e.due = (7 + 1) * FU;
    e.total = SMAXM; e.chg = SMAXM - (7 + 1) * FU; e.tickets = 1; e.end_cyc = 0;
    sq.push_back(e);
    s_ready = 1'b1;
    @(posedge clk); #1;
    s_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("sat_idle", int'(s_busy), 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q.size() + sq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ticket_vending_ctrl.md
Name: ticket_vending_ctrl

Overview:
Parametrised successor to the station-ticket vending FSM. It prices a multi-ticket journey between numbered stations, accumulates coins through a valid-qualified input, and dispenses tickets one at a time over a valid/ready handshake. It then returns change. It adds cancel, inactivity timeout and saturating money arithmetic, and sits between the front-panel input logic and the ticket/coin dispenser drivers.

Parameters:
STATION_W, 3, width of origin/destination station index
TICKET_W, 3, width of ticket-count request
COIN_W, 6, width of one inserted coin value
MONEY_W, 10, width of all money registers; must hold (2^STATION_W)*FARE_UNIT*(2^TICKET_W-1)
FARE_UNIT, 5, price per station spanned (inclusive count)
TIMEOUT_CYC, 255, idle cycles allowed in payment before auto-cancel (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  transaction request; sampled only in IDLE
origin  in  STATION_W  origin station, latched on accepted start
destination  in  STATION_W  destination station, latched on accepted start
howManyTicket  in  TICKET_W  ticket count, latched on accepted start
coin_valid  in  1  money valid this cycle
money  in  COIN_W  coin value
cancel  in  1  user cancel request
ticket_ready  in  1  dispenser accepts a ticket
costOfTicket  out  MONEY_W  per-ticket fare
moneyToPay  out  MONEY_W  total due
totalMoney  out  MONEY_W  money inserted so far
change  out  MONEY_W  amount to return; valid with done or cancelled
ticket_valid  out  1  ticket offered to dispenser
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: transaction completed
cancelled  out  1  one-cycle pulse: transaction aborted (user or timeout)

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; internal ticket and timeout counters 0.
- States: IDLE, PRICE, TOTAL, PAY, DISPENSE, FINISH, REFUND. All outputs are registered.
- IDLE: start=1 and howManyTicket!=0 latches the inputs and goes to PRICE. start with howManyTicket==0 is ignored and the FSM stays in IDLE. Outputs keep the previous transaction's values until the next accepted start.
- PRICE: costOfTicket <= (|destination-origin|+1)*FARE_UNIT. origin==destination gives FARE_UNIT. moneyToPay, totalMoney and change are cleared. Next state is TOTAL.
- TOTAL: moneyToPay <= howManyTicket*costOfTicket. Timeout counter is loaded with TIMEOUT_CYC. Next state is PAY.
- PAY, per cycle, in priority order:
  1) cancel=1: go to REFUND. A coin arriving in the same cycle is NOT added (the coin path rejects it externally).
  2) coin_valid=1: totalMoney <= sat(totalMoney+money), saturating at 2^MONEY_W-1. Timeout counter reloads. If the new sum >= moneyToPay, go to DISPENSE next cycle.
  3) Otherwise the timeout counter decrements. Reaching 0 goes to REFUND.
- Latency: for the coin that satisfies moneyToPay, the registered totalMoney and state=DISPENSE are both visible on the next edge.
- DISPENSE: ticket_valid=1. Each cycle with ticket_valid&ticket_ready counts one ticket. ticket_valid stays high until the howManyTicket-th handshake, then drops the following cycle and the FSM goes to FINISH. cancel and coins are ignored in DISPENSE. ticket_ready held low stalls indefinitely (no timeout).
- FINISH: change <= totalMoney-moneyToPay (never negative). done=1 for exactly this one cycle. Next state is IDLE.
- REFUND: change <= totalMoney, which may be 0. cancelled=1 for one cycle. Next state is IDLE.
- done and cancelled are never high in the same cycle. busy=0 only in IDLE.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. Inserted money is not reported; the coin mechanism handles refund on reset.
- start while busy is ignored.

Test Plan:
- Normal purchase: origin=2, destination=5, howManyTicket=2; coins 20,10,15; ticket_ready=1 -> costOfTicket=20, moneyToPay=40, totalMoney=45, 2 ticket handshakes, change=5, done pulse, busy falls.
- Reverse and zero-span: origin=6, destination=1 -> costOfTicket=30. origin=destination=3 -> costOfTicket=5. howManyTicket=0 start -> stays IDLE, busy=0.
- Cancel: route 1->4, 1 ticket (due 20); coin 10, then cancel and a 5-coin in the same cycle -> cancelled pulse, change=10, no ticket_valid.
- Timeout: TIMEOUT_CYC=8, coin 5, then no activity -> cancelled exactly 8 cycles after the last coin's cycle, change=5. A coin at count 1 reloads the counter.
- Backpressure: 3 tickets, ticket_ready toggling 1,0,0,1,0,1 -> exactly 3 handshakes, ticket_valid drops after the third, cancel asserted during DISPENSE ignored, done once.
- Async reset mid-DISPENSE (after 1 of 3 tickets) -> outputs 0 without waiting for a clock edge. A new start then completes normally. Saturation: 60-coins with MONEY_W=6 clamp totalMoney at 63.
